alu_exec_stage: RTL and testbench

//  Registered RV32 execute stage directly downstream of the ALU decoder: consumes its 4-bit ALUControl plus operands.

---
 rtl/alu_exec_stage.sv | 85 ++++++++
 tb/tb_alu_exec_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered RV32 execute stage with serial shifter and valid/ready handshake
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] cnt, shamt;
  logic [1:0] kind;
  logic accept, is_shift, ill;
  logic [XLEN-1:0] alu_res, ld, shifted, uimm;
  always_comb begin
    uimm = XLEN'({src_b[19:0], 12'b0});
    shamt = src_b[SW-1:0];
    is_shift = alu_control inside {4'b1010, 4'b1011, 4'b1100};
    ill = alu_control inside {4'b0111, 4'b1101, 4'b1110, 4'b1111};
    case (alu_control)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010: alu_res = src_a & src_b;
      4'b0011: alu_res = src_a | src_b;
      4'b0100: alu_res = src_a ^ src_b;
      4'b0101: alu_res = XLEN'($signed(src_a) < $signed(src_b));
      4'b0110: alu_res = XLEN'(src_a < src_b);
      4'b1000: alu_res = src_a + uimm;
      4'b1001: alu_res = uimm;
      default: alu_res = '0;
    endcase
    ld = is_shift ? src_a : alu_res;
    shifted = kind == 2'b10 ? result << 1 :
              kind == 2'b11 ? {result[XLEN-1], result[XLEN-1:1]} : result >> 1;
    in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    accept = in_valid && in_ready;
    state_nx = flush ? IDLE :
               accept ? ((is_shift && shamt != '0) ? SHIFT : DONE) :
               (state == DONE && out_ready) ? IDLE :
               (state == SHIFT && cnt == SW'(1)) ? DONE : state;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // the result register doubles as the shifter's working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      zero <= 1'b0;
      illegal <= 1'b0;
      out_tag <= '0;
      cnt <= '0;
      kind <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        result <= ld;
        zero <= ld == '0;
        illegal <= ill;
        out_tag <= in_tag;
        cnt <= shamt;
        kind <= alu_control[1:0];
      end else if (state == SHIFT && !flush) begin
        result <= shifted;
        zero <= shifted == '0;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized and directed checks of alu_exec_stage against a behavioural model
module tb_alu_exec_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero, illegal, busy;
  logic [3:0] alu_control = 0;
  logic [31:0] src_a = 0, src_b = 0, result;
  logic [4:0] in_tag = 0, out_tag;
  int n_chk = 0, n_err = 0;
  logic m_pend = 0, m_ill = 0;
  int m_wait = 0;
  logic [31:0] m_res = 0;
  logic [4:0] m_tag = 0;

  alu_exec_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .out_tag(out_tag), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int s = int'(b[4:0]);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return a + (b << 12);
      4'd9: return b << 12;
      4'd10: return a << s;
      4'd11: return $signed(a) >>> s;
      4'd12: return a >> s;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // model: pending result becomes visible after m_wait more edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0;
      m_wait = 0;
    end else begin
      logic ir;
      ir = !flush && (!m_pend || (m_wait == 0 && out_ready));
      if (flush) m_pend = 0;
      else if (in_valid && ir) begin
        m_pend = 1;
        m_res = exp_res(alu_control, src_a, src_b);
        m_ill = alu_control inside {4'd7, 4'd13, 4'd14, 4'd15};
        m_tag = in_tag;
        m_wait = (alu_control inside {4'd10, 4'd11, 4'd12}) ? int'(src_b[4:0]) : 0;
      end else if (m_pend && m_wait == 0 && out_ready) m_pend = 0;
      else if (m_pend && m_wait > 0) m_wait--;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!flush && (!m_pend || (m_wait == 0 && out_ready))));
      chk("out_valid", 32'(out_valid), 32'(m_pend && m_wait == 0));
      chk("busy", 32'(busy), 32'(m_pend));
      if (m_pend && m_wait == 0) begin
        chk("result", result, m_res);
        chk("zero", 32'(zero), 32'(m_res == 0));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("out_tag", 32'(out_tag), 32'(m_tag));
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    logic acc = 0;
    alu_control = c; src_a = a; src_b = b; in_tag = t; in_valid = 1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k;
    chk("model_add", exp_res(4'd0, 5, 7), 32'd12);
    chk("model_slt", exp_res(4'd5, 32'hFFFFFFFF, 1), 32'd1);
    chk("model_sra", exp_res(4'd11, 32'h80000000, 4), 32'hF8000000);
    chk("model_lui", exp_res(4'd9, 0, 32'h12345), 32'h12345000);
    chk("model_auipc", exp_res(4'd8, 32'h100, 1), 32'h1100);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, illegal, busy}, 0);
    chk("rst_tag", 32'(out_tag), 0);
    #21 rst_n = 1;
    @(posedge clk); #1;
    drive(4'd0, 5, 7, 3);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_result", result, 12);
    chk("add_tag", 32'(out_tag), 3);
    chk("add_flags", {zero, illegal}, 0);
    drive(4'd1, 9, 9, 1);
    chk("sub_result", result, 0);
    chk("sub_zero", 32'(zero), 1);
    drive(4'd5, 32'hFFFFFFFF, 1, 2);
    chk("slt_result", result, 1);
    chk("slt_valid", 32'(out_valid), 1);
    in_valid = 0;
    drive(4'd11, 32'h80000000, 4, 5);
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 50) begin
      chk("sra_in_ready_low", 32'(in_ready), 0);
      @(posedge clk); #1;
      k++;
    end
    chk("sra_latency", k, 4);
    chk("sra_result", result, 32'hF8000000);
    drive(4'd11, 32'h80000000, 0, 6);
    chk("sra0_valid", 32'(out_valid), 1);
    chk("sra0_result", result, 32'h80000000);
    in_valid = 0;
    @(posedge clk); #1;
    out_ready = 0;
    drive(4'd0, 1, 1, 7);
    in_valid = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_result", result, 2);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    idle(1);
    drive(4'd10, 1, 31, 8);
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_busy", 32'(busy), 0);
    idle(2);
    drive(4'd13, 32'h55, 32'h66, 9);
    chk("ill_result", result, 0);
    chk("ill_flags", {zero, illegal}, 3);
    drive(4'd9, 32'hDEAD, 32'h12345, 10);
    chk("lui_result", result, 32'h12345000);
    drive(4'd8, 32'h100, 1, 11);
    chk("auipc_result", result, 32'h1100);
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      alu_control = 4'($urandom_range(0, 15));
      src_a = $urandom;
      src_b = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
      in_tag = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      @(posedge clk); #1;
    end
    flush = 0; out_ready = 1;
    idle(40);
    drive(4'd10, 32'h3, 20, 12);
    in_valid = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {zero, illegal, busy}, 0);
    chk("midrst_tag", 32'(out_tag), 0);
    #8 rst_n = 1;
    idle(2);
    drive(4'd4, 32'hF0F0, 32'h0FF0, 13);
    chk("post_rst_xor", result, 32'hFF00);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
